// File: rtl/bcd_time_display_scan_if.sv
`default_nettype none
// ============================================================================
// Module      : bcd_time_display_scan_if
// Description : 12-hour BCD time bus plus the multiplexed 7-segment display
//               signals of the scan block.
// Revision    : 1.0 - initial release
// ============================================================================
interface bcd_time_display_scan_if;
    logic       pm;
    logic [7:0] hh;
    logic [7:0] mm;
    logic [7:0] ss;
    logic [6:0] seg;
    logic       dp;
    logic [5:0] an;
    logic       frame;
    logic       bcd_err;

    modport master (
        output pm, hh, mm, ss,
        input  seg, dp, an, frame, bcd_err
    );

    modport slave (
        input  pm, hh, mm, ss,
        output seg, dp, an, frame, bcd_err
    );
endinterface
`default_nettype wire

// File: rtl/bcd_time_display_scan.sv
`default_nettype none
// ============================================================================
// Module      : bcd_time_display_scan
// Description : Snapshots the BCD time once per frame and scans six digits
//               onto one 7-segment bus. Option macro: LEADING_ZERO_BLANK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_time_display_scan #(
    parameter int SCAN_DIV   = 1000,
    parameter int BLANK_CYC  = 4,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    bcd_time_display_scan_if.slave        bus
);

    localparam logic [15:0] c_CNT_MAX = 16'(SCAN_DIV - 1);
    localparam logic [15:0] c_BLANK   = 16'(BLANK_CYC);
    localparam logic        c_INV     = (ACTIVE_LOW != 0);

    logic [15:0] r_cnt;
    logic [2:0]  r_idx;
    logic        r_snap_valid;
    logic        r_pm;
    logic [7:0]  r_hh;
    logic [7:0]  r_mm;
    logic [7:0]  r_ss;
    logic        r_chk_pend;
    logic [6:0]  r_seg;
    logic        r_dp;
    logic [5:0]  r_an;
    logic        r_frame;
    logic        r_bcd_err;

    logic        w_tick;
    logic        w_capture;
    logic [3:0]  w_nib;
    logic [6:0]  w_seg;
    logic        w_dp;
    logic [5:0]  w_an;
    logic        w_bad;

    function automatic logic [6:0] f_decode(input logic [3:0] i_nib);
        logic [6:0] v;
        case (i_nib)
            4'd0:    v = 7'h3F;
            4'd1:    v = 7'h06;
            4'd2:    v = 7'h5B;
            4'd3:    v = 7'h4F;
            4'd4:    v = 7'h66;
            4'd5:    v = 7'h6D;
            4'd6:    v = 7'h7D;
            4'd7:    v = 7'h07;
            4'd8:    v = 7'h7F;
            4'd9:    v = 7'h6F;
            default: v = 7'h40;
        endcase
        return v;
    endfunction

    always_comb begin
        w_tick    = (r_cnt == c_CNT_MAX);
        w_capture = !r_snap_valid || (w_tick && (r_idx == 3'd5));

        case (r_idx)
            3'd0:    w_nib = r_ss[3:0];
            3'd1:    w_nib = r_ss[7:4];
            3'd2:    w_nib = r_mm[3:0];
            3'd3:    w_nib = r_mm[7:4];
            3'd4:    w_nib = r_hh[3:0];
            3'd5:    w_nib = r_hh[7:4];
            default: w_nib = 4'h0;
        endcase

        w_seg = f_decode(w_nib);
        w_dp  = (r_idx == 3'd2) || (r_idx == 3'd4) || ((r_idx == 3'd0) && r_pm);
`ifdef LEADING_ZERO_BLANK_EN
        if ((r_idx == 3'd5) && (r_hh[7:4] == 4'h0)) begin
            w_seg = 7'h00;
            w_dp  = 1'b0;
        end
`endif

        // Anodes stay dark during the blanking window and until the first snapshot exists
        if ((r_cnt >= c_BLANK) && r_snap_valid)
            w_an = 6'b000001 << r_idx;
        else
            w_an = 6'b000000;

        w_bad = (r_ss[3:0] > 4'd9) || (r_ss[7:4] > 4'd9) ||
                (r_mm[3:0] > 4'd9) || (r_mm[7:4] > 4'd9) ||
                (r_hh[3:0] > 4'd9) || (r_hh[7:4] > 4'd9) ||
                (r_ss > 8'h59) || (r_mm > 8'h59) ||
                (r_hh == 8'h00) || (r_hh > 8'h12);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_snap_valid <= 1'b0;
            r_pm         <= 1'b0;
            r_hh         <= '0;
            r_mm         <= '0;
            r_ss         <= '0;
            r_chk_pend   <= 1'b0;
            r_seg        <= {7{c_INV}};
            r_dp         <= c_INV;
            r_an         <= {6{c_INV}};
            r_frame      <= 1'b0;
            r_bcd_err    <= 1'b0;
        end else begin
            r_cnt <= w_tick ? 16'd0 : r_cnt + 16'd1;
            if (w_tick)
                r_idx <= (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;

            if (w_capture) begin
                r_pm         <= bus.pm;
                r_hh         <= bus.hh;
                r_mm         <= bus.mm;
                r_ss         <= bus.ss;
                r_snap_valid <= 1'b1;
            end
            r_frame    <= w_capture;
            r_chk_pend <= w_capture;

            // Validity is judged on the freshly captured snapshot, one cycle later
            if (r_chk_pend && w_bad)
                r_bcd_err <= 1'b1;

            r_seg <= w_seg ^ {7{c_INV}};
            r_dp  <= w_dp ^ c_INV;
            r_an  <= w_an ^ {6{c_INV}};
        end
    end

    assign bus.seg     = r_seg;
    assign bus.dp      = r_dp;
    assign bus.an      = r_an;
    assign bus.frame   = r_frame;
    assign bus.bcd_err = r_bcd_err;

endmodule
`default_nettype wire

// File: tb/tb_bcd_time_display_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_time_display_scan
// Description : Directed self-checking bench (SCAN_DIV=8, BLANK_CYC=2) with an
//               extra ACTIVE_LOW=1 instance sharing the same time bus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_time_display_scan;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    bcd_time_display_scan_if bus ();
    bcd_time_display_scan_if bus_n ();

    assign bus_n.pm = bus.pm;
    assign bus_n.hh = bus.hh;
    assign bus_n.mm = bus.mm;
    assign bus_n.ss = bus.ss;

    bcd_time_display_scan #(.SCAN_DIV(8), .BLANK_CYC(2), .ACTIVE_LOW(0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    bcd_time_display_scan #(.SCAN_DIV(8), .BLANK_CYC(2), .ACTIVE_LOW(1)) dut_n (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_n.slave)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Leaves the bench 1 time unit after a clock edge with reset released; the next edge is edge 1
    task automatic do_reset(input logic p, input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        reset  = 1'b1;
        bus.pm = p;
        bus.hh = h;
        bus.mm = m;
        bus.ss = s;
        #23;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        bus.pm = 1'b1;
        bus.hh = 8'h01;
        bus.mm = 8'h00;
        bus.ss = 8'h00;
        #23;
        checks++;
        if ({bus.seg, bus.dp, bus.an, bus.frame, bus.bcd_err} !== 16'h0000) begin
            errors++;
            $display("FAIL reset_outputs got seg=%h dp=%b an=%b frame=%b err=%b want all 0",
                     bus.seg, bus.dp, bus.an, bus.frame, bus.bcd_err);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(1);
        checks++;
        if (bus.frame !== 1'b1 || bus.an !== 6'b000000) begin
            errors++;
            $display("FAIL reset_first_edge got frame=%b an=%b want frame=1 an=000000", bus.frame, bus.an);
        end
        step(1);
        checks++;
        if (bus.frame !== 1'b0 || bus.an !== 6'b000000 || bus.seg !== 7'h3F || bus.dp !== 1'b1) begin
            errors++;
            $display("FAIL reset_edge2 got frame=%b an=%b seg=%h dp=%b want 0 000000 3f 1",
                     bus.frame, bus.an, bus.seg, bus.dp);
        end
        step(1);
        checks++;
        if (bus.an !== 6'b000001) begin
            errors++;
            $display("FAIL reset_edge3_an got %b want 000001", bus.an);
        end
    endtask

    task automatic test_scan_order();
        logic [6:0] seg_tab [6];
        logic [5:0] exp_an;
        logic       exp_frame;
        int         slot;
        int         pos;
        seg_tab = '{7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06};
        do_reset(1'b0, 8'h12, 8'h34, 8'h56);
        for (int e = 1; e <= 49; e++) begin
            step(1);
            slot      = ((e - 1) / 8) % 6;
            pos       = (e - 1) % 8;
            exp_an    = (pos >= 2) ? (6'b000001 << slot) : 6'b000000;
            exp_frame = (e == 1) || (e == 48);
            checks++;
            if (bus.an !== exp_an || bus.frame !== exp_frame) begin
                errors++;
                $display("FAIL scan_an_frame edge=%0d got an=%b frame=%b want an=%b frame=%b",
                         e, bus.an, bus.frame, exp_an, exp_frame);
            end
            if (pos == 4) begin
                checks++;
                if (bus.seg !== seg_tab[slot] || bus.dp !== ((slot == 2) || (slot == 4))) begin
                    errors++;
                    $display("FAIL scan_seg_dp slot=%0d got seg=%h dp=%b want seg=%h dp=%b",
                             slot, bus.seg, bus.dp, seg_tab[slot], (slot == 2) || (slot == 4));
                end
            end
        end
        checks++;
        if (bus.bcd_err !== 1'b0) begin
            errors++;
            $display("FAIL scan_no_err got %b want 0", bus.bcd_err);
        end
    endtask

    task automatic test_coherency();
        do_reset(1'b0, 8'h12, 8'h34, 8'h56);
        step(16);
        bus.ss = 8'h57;
        bus.mm = 8'h45;
        step(5);
        checks++;
        if (bus.seg !== 7'h66) begin
            errors++;
            $display("FAIL coh_mm_ones_old got %h want 66", bus.seg);
        end
        step(8);
        checks++;
        if (bus.seg !== 7'h4F) begin
            errors++;
            $display("FAIL coh_mm_tens_old got %h want 4f", bus.seg);
        end
        step(24);
        checks++;
        if (bus.seg !== 7'h07 || bus.an !== 6'b000001) begin
            errors++;
            $display("FAIL coh_ss_ones_new got seg=%h an=%b want 07 000001", bus.seg, bus.an);
        end
        step(16);
        checks++;
        if (bus.seg !== 7'h6D || bus.an !== 6'b000100) begin
            errors++;
            $display("FAIL coh_mm_ones_new got seg=%h an=%b want 6d 000100", bus.seg, bus.an);
        end
    endtask

    task automatic test_error_ranges();
        logic [24:0] vec [8];
        vec = '{{8'h12, 8'h59, 8'h59, 1'b0}, {8'h01, 8'h00, 8'h00, 1'b0},
                {8'h00, 8'h00, 8'h00, 1'b1}, {8'h13, 8'h00, 8'h00, 1'b1},
                {8'h12, 8'h60, 8'h00, 1'b1}, {8'h12, 8'h00, 8'h60, 1'b1},
                {8'h0A, 8'h00, 8'h00, 1'b1}, {8'h12, 8'h0F, 8'h00, 1'b1}};
        for (int i = 0; i < 8; i++) begin
            do_reset(1'b0, vec[i][24:17], vec[i][16:9], vec[i][8:1]);
            step(3);
            checks++;
            if (bus.bcd_err !== vec[i][0]) begin
                errors++;
                $display("FAIL err_range hh=%h mm=%h ss=%h got %b want %b",
                         vec[i][24:17], vec[i][16:9], vec[i][8:1], bus.bcd_err, vec[i][0]);
            end
        end
    endtask

    task automatic test_error_sticky();
        do_reset(1'b0, 8'h12, 8'h34, 8'h6A);
        step(5);
        checks++;
        if (bus.bcd_err !== 1'b1 || bus.seg !== 7'h40) begin
            errors++;
            $display("FAIL err_dash got err=%b seg=%h want 1 40", bus.bcd_err, bus.seg);
        end
        bus.ss = 8'h00;
        step(48);
        checks++;
        if (bus.bcd_err !== 1'b1 || bus.seg !== 7'h3F) begin
            errors++;
            $display("FAIL err_sticky got err=%b seg=%h want 1 3f", bus.bcd_err, bus.seg);
        end
    endtask

    task automatic test_async_reset();
        do_reset(1'b0, 8'h12, 8'h34, 8'h56);
        step(21);
        checks++;
        if (bus.an !== 6'b000100) begin
            errors++;
            $display("FAIL arst_pre got an=%b want 000100", bus.an);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.an !== 6'b000000 || bus.seg !== 7'h00 || bus.dp !== 1'b0) begin
            errors++;
            $display("FAIL arst_immediate got an=%b seg=%h dp=%b want 000000 00 0", bus.an, bus.seg, bus.dp);
        end
        #2;
        reset = 1'b0;
        step(1);
        checks++;
        if (bus.frame !== 1'b1) begin
            errors++;
            $display("FAIL arst_frame got %b want 1", bus.frame);
        end
        step(2);
        checks++;
        if (bus.an !== 6'b000001 || bus.seg !== 7'h7D) begin
            errors++;
            $display("FAIL arst_restart got an=%b seg=%h want 000001 7d", bus.an, bus.seg);
        end
    endtask

    task automatic test_leading_zero();
        logic [6:0] exp_seg;
`ifdef LEADING_ZERO_BLANK_EN
        exp_seg = 7'h00;
`else
        exp_seg = 7'h3F;
`endif
        do_reset(1'b0, 8'h09, 8'h00, 8'h00);
        step(45);
        checks++;
        if (bus.seg !== exp_seg || bus.an !== 6'b100000 || bus.dp !== 1'b0) begin
            errors++;
            $display("FAIL lead_zero got seg=%h an=%b dp=%b want %h 100000 0", bus.seg, bus.an, bus.dp, exp_seg);
        end
    endtask

    task automatic test_active_low();
        reset  = 1'b1;
        bus.pm = 1'b0;
        bus.hh = 8'h12;
        bus.mm = 8'h34;
        bus.ss = 8'h16;
        #23;
        checks++;
        if (bus_n.seg !== 7'h7F || bus_n.an !== 6'h3F || bus_n.dp !== 1'b1) begin
            errors++;
            $display("FAIL al_reset got seg=%h an=%b dp=%b want 7f 111111 1", bus_n.seg, bus_n.an, bus_n.dp);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(13);
        checks++;
        if (bus_n.seg !== 7'h79 || bus_n.an !== 6'b111101 || bus_n.dp !== 1'b1) begin
            errors++;
            $display("FAIL al_digit1 got seg=%h an=%b dp=%b want 79 111101 1", bus_n.seg, bus_n.an, bus_n.dp);
        end
    endtask

    initial begin
        bus.pm = 1'b0;
        bus.hh = 8'h00;
        bus.mm = 8'h00;
        bus.ss = 8'h00;
        test_reset();
        test_scan_order();
        test_coherency();
        test_error_ranges();
        test_error_sticky();
        test_async_reset();
        test_leading_zero();
        test_active_low();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
